// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for a single-issue RISC-V core.
// Owns the PC, drives a no-outstanding-transaction request/ready handshake to
// instruction memory, and buffers one fetched instruction for decode.
// Handles decode back-pressure, branch/jump redirects and misaligned targets.
//
// Parameters:
//   RESET_PC        PC loaded on reset
//   PC_STEP         PC increment after each completed fetch
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   imem_req/addr   fetch request and address (addr always equals the PC)
//   imem_ready      memory response valid, imem_rdata the returned word
//   if_valid/pc/instr  buffered instruction toward decode
//   id_ready        decode accepts the buffered instruction
//   redirect_valid/target  taken branch/jump, flush and refetch
//   fault           sticky misaligned-redirect fault
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count and stall_count.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StStall, StErr} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;
  logic        fire;

  assign imem_req  = (state_q == StFetch) && (!valid_q || id_ready);
  assign imem_addr = pc_q;
  assign fire      = imem_req && imem_ready;
  assign if_valid  = valid_q;
  assign if_pc     = ipc_q;
  assign if_instr  = instr_q;
  assign fault     = fault_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (fire) begin
          // Accept and refill in the same cycle: the buffer is simply replaced.
          valid_d = 1'b1;
          ipc_d   = pc_q;
          instr_d = imem_rdata;
          pc_d    = pc_q + PC_STEP;
        end else if (valid_q && id_ready) begin
          valid_d = 1'b0;
        end else if (valid_q && !id_ready) begin
          state_d = StStall;
        end
      end
      StStall: begin
        if (id_ready) begin
          valid_d = 1'b0;
          state_d = StFetch;
        end
      end
      StErr: ;
      default: state_d = StErr;
    endcase
    // Redirect overrides everything above, including a same-cycle response.
    if (redirect_valid && state_q != StErr) begin
      valid_d = 1'b0;
      if (redirect_target[1:0] != 2'b00) begin
        state_d = StErr;
        fault_d = 1'b1;
        pc_d    = pc_q;
      end else begin
        state_d = StFetch;
        pc_d    = redirect_target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ipc_q   <= 32'h0;
      instr_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc, stall_inc;
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  assign fetch_inc   = fire && !redirect_valid;
  assign stall_inc   = (state_q == StStall) || (imem_req && !imem_ready);
  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (fetch_inc && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_inc && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

endmodule
